// File: rtl/div_result_fifo.sv
// Result FIFO behind the divider: captures one-cycle result pulses and replays them on a ready/valid stream.
// Optional per-entry divide-by-zero flag enabled by defining DIV_RESULT_FIFO_DZ_FLAG_EN.
module div_result_fifo #(
  parameter int DEPTH     = 4,
  parameter int AF_MARGIN = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_valid,
  input  logic [31:0]                i_payload_1,
  input  logic [31:0]                i_payload_2,
  output logic                       i_almost_full,
  input  logic                       o_ready,
  output logic                       o_valid,
  output logic [31:0]                o_payload_1,
  output logic [31:0]                o_payload_2,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
`ifdef DIV_RESULT_FIFO_DZ_FLAG_EN
  ,
  output logic                       o_payload_dz
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef DIV_RESULT_FIFO_DZ_FLAG_EN
  localparam int EW = 65;
`else
  localparam int EW = 64;
`endif

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;

  // Handshake: the output side transfers an entry on any rising edge where
  // o_valid && o_ready; the input side has no ready, so i_valid is a strobe
  // that is either stored or dropped (and flagged) in the same cycle.
  assign w_pop  = (r_count != '0) && o_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign w_full = (r_count == CW'(DEPTH)) && !w_pop;
  assign w_push = i_valid && !w_full;
  assign w_drop = i_valid && w_full;

`ifdef DIV_RESULT_FIFO_DZ_FLAG_EN
  assign w_entry = {(i_payload_1 == 32'hFFFF_FFFF) && (i_payload_2 == 32'hFFFF_FFFF),
                    i_payload_2, i_payload_1};
`else
  assign w_entry = {i_payload_2, i_payload_1};
`endif

  // Storage is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign o_valid       = (r_count != '0);
  assign o_count       = r_count;
  assign o_overflow    = r_overflow;
  assign i_almost_full = (r_count >= CW'(DEPTH - AF_MARGIN));
  assign o_payload_1   = o_valid ? w_head[31:0]  : 32'd0;
  assign o_payload_2   = o_valid ? w_head[63:32] : 32'd0;
`ifdef DIV_RESULT_FIFO_DZ_FLAG_EN
  assign o_payload_dz  = o_valid ? w_head[64] : 1'b0;
`endif

endmodule

// File: tb/tb_div_result_fifo.sv
// Self-checking bench for div_result_fifo: directed scenarios plus random traffic against a queue model.
// Also exercises the divide-by-zero flag when DIV_RESULT_FIFO_DZ_FLAG_EN is defined.
module tb_div_result_fifo;

  localparam int DEPTH     = 4;
  localparam int AF_MARGIN = 1;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          i_valid;
  logic [31:0]   i_payload_1;
  logic [31:0]   i_payload_2;
  logic          i_almost_full;
  logic          o_ready;
  logic          o_valid;
  logic [31:0]   o_payload_1;
  logic [31:0]   o_payload_2;
  logic [CW-1:0] o_count;
  logic          o_overflow;
  logic          dut_dz;

  div_result_fifo #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_valid       (i_valid),
    .i_payload_1   (i_payload_1),
    .i_payload_2   (i_payload_2),
    .i_almost_full (i_almost_full),
    .o_ready       (o_ready),
    .o_valid       (o_valid),
    .o_payload_1   (o_payload_1),
    .o_payload_2   (o_payload_2),
    .o_count       (o_count),
    .o_overflow    (o_overflow)
`ifdef DIV_RESULT_FIFO_DZ_FLAG_EN
    ,
    .o_payload_dz  (dut_dz)
`endif
  );

`ifndef DIV_RESULT_FIFO_DZ_FLAG_EN
  assign dut_dz = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [64:0] exp_q[$];   // {dz, remainder, quotient}
  int          m_count;
  bit          m_ovf;
  int          n_checks;
  int          n_pass;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Compare every externally visible status output against the model.
  task automatic check_state(input string tag);
    chk({tag, " count"},    65'(o_count),       65'(m_count));
    chk({tag, " valid"},    65'(o_valid),       65'(m_count != 0));
    chk({tag, " af"},       65'(i_almost_full), 65'(m_count >= DEPTH - AF_MARGIN));
    chk({tag, " overflow"}, 65'(o_overflow),    65'(m_ovf));
    if (m_count == 0) begin
      chk({tag, " empty p1"}, 65'(o_payload_1), 65'd0);
      chk({tag, " empty p2"}, 65'(o_payload_2), 65'd0);
      chk({tag, " empty dz"}, 65'(dut_dz),      65'd0);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle, updates the model, and checks state just after the edge.
  task automatic step(input logic v, input logic [31:0] p1, input logic [31:0] p2,
                      input logic r, input string tag);
    bit pop;
    logic dz;
    i_valid     = v;
    i_payload_1 = p1;
    i_payload_2 = p2;
    o_ready     = r;
    pop = (m_count > 0) && r;
    if (v) begin
      if (m_count == DEPTH && !pop) m_ovf = 1'b1;
      else begin
`ifdef DIV_RESULT_FIFO_DZ_FLAG_EN
        dz = (p1 == 32'hFFFF_FFFF) && (p2 == 32'hFFFF_FFFF);
`else
        dz = 1'b0;
`endif
        exp_q.push_back({dz, p2, p1});
        m_count++;
      end
    end
    if (pop) m_count--;
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic apply_reset(input string tag);
    i_valid = 1'b0;
    #2;
    reset = 1'b1;
    exp_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    #1;
    check_state({tag, " async"});
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_state({tag, " post"});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 32'd0, 32'd0, 1'b1, tag);
    chk({tag, " scoreboard empty"}, 65'(exp_q.size()), 65'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [64:0] e;
    if (!reset && o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected output", {dut_dz, o_payload_2, o_payload_1}, 65'h0);
      end else begin
        e = exp_q.pop_front();
        chk("out quotient",  65'(o_payload_1), 65'(e[31:0]));
        chk("out remainder", 65'(o_payload_2), 65'(e[63:32]));
`ifdef DIV_RESULT_FIFO_DZ_FLAG_EN
        chk("out dz",        65'(dut_dz),      65'(e[64]));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_count  = 0;
    m_ovf    = 1'b0;
    reset       = 1'b1;
    i_valid     = 1'b0;
    i_payload_1 = '0;
    i_payload_2 = '0;
    o_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    reset = 1'b0;
    repeat (2) step(1'b0, 32'd0, 32'd0, 1'b0, "idle");

    // Single write with consumer ready: visible next cycle, popped there.
    step(1'b1, 32'd3, 32'd2, 1'b1, "single wr");
    chk("single head q", 65'(o_payload_1), 65'd3);
    chk("single head r", 65'(o_payload_2), 65'd2);
    step(1'b0, 32'd0, 32'd0, 1'b1, "single pop");

    // Fill to full, then one dropped write.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 32'd0, 1'b0, "fill");
    chk("full af", 65'(i_almost_full), 65'd1);
    step(1'b1, 32'd5, 32'd0, 1'b0, "overflow wr");
    chk("overflow set", 65'(o_overflow), 65'd1);
    drain("drain 1-4");
    apply_reset("rst1");

    // Full FIFO with simultaneous pop and write: accepted, no overflow.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'(i + 10), 32'(i), 1'b0, "refill");
    step(1'b1, 32'd9, 32'd9, 1'b1, "full push+pop");
    chk("full push+pop count", 65'(o_count), 65'(DEPTH));
    chk("full push+pop ovf",   65'(o_overflow), 65'd0);
    drain("drain with 9");

    // Streaming: ten back-to-back writes, consumer always ready.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'(100 + i), 32'(i), 1'b1, "stream");
      chk("stream count<=1", 65'(o_count <= 1), 65'd1);
    end
    drain("stream drain");

`ifdef DIV_RESULT_FIFO_DZ_FLAG_EN
    step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "dz wr");
    step(1'b1, 32'd3, 32'd2, 1'b0, "dz normal wr");
    chk("dz head flag", 65'(dut_dz), 65'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, "dz pop");
    chk("dz second flag", 65'(dut_dz), 65'd0);
    drain("dz drain");
`endif

    // Reset mid-drain clears the output side immediately.
    for (int i = 0; i < 3; i++) step(1'b1, 32'(200 + i), 32'(7), 1'b0, "pre-rst");
    step(1'b0, 32'd0, 32'd0, 1'b1, "mid drain");
    o_ready = 1'b1;
    apply_reset("rst mid drain");
    o_ready = 1'b0;

    // Random traffic including overflow and all-ones results.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] p1;
      logic [31:0] p2;
      if ($urandom_range(0, 7) == 0) begin
        p1 = 32'hFFFF_FFFF;
        p2 = 32'hFFFF_FFFF;
      end else begin
        p1 = $urandom;
        p2 = $urandom;
      end
      step(logic'($urandom_range(0, 99) < 60), p1, p2,
           logic'($urandom_range(0, 99) < 45), "random");
    end
    drain("random drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
